crossing_request: RTL and testbench

Front-end request stage for the pedestrian/cyclist crossing controller. It takes the raw, asynchronous crossing pushbutton, synchronises and debounces it, and latches the press as a pending request. It drives the controller's `start` input as a level until the walk phase begins, and it lights a WAIT lamp while a request is outstanding. After each walk phase it enforces a minimum hold-off before a new `start` can be issued, and it counts completed crossings.

---
 rtl/crossing_request_if.sv | 33 +++
 rtl/crossing_request.sv | 127 ++++++++++++
 tb/tb_crossing_request.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/crossing_request_if.sv
// ---------------------------------------------------------------------------
// crossing_request_if
// Signal bundle between the crossing pushbutton front end and its neighbours.
//   button       : raw pushbutton, active-high, asynchronous, may bounce
//   walk         : controller walk-phase indicator (lightseq bit 0)
//   start        : registered crossing request level to the controller
//   wait_lamp    : registered WAIT indicator
//   served_count : completed walk phases, saturating at 255
// The slave modport is the request stage; master is the surrounding system.
// ---------------------------------------------------------------------------
interface crossing_request_if;
  logic       button;
  logic       walk;
  logic       start;
  logic       wait_lamp;
  logic [7:0] served_count;

  modport master (
    output button,
    output walk,
    input  start,
    input  wait_lamp,
    input  served_count
  );

  modport slave (
    input  button,
    input  walk,
    output start,
    output wait_lamp,
    output served_count
  );
endinterface

// File: rtl/crossing_request.sv
// ---------------------------------------------------------------------------
// crossing_request
// Front-end request stage for the crossing controller. Synchronises and
// debounces the pushbutton, latches a press as a pending request, drives
// start until the walk phase begins, enforces a hold-off after each walk
// phase and counts completed crossings.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high, clears every register
//   bus   : crossing_request_if.slave (button, walk in; start, wait_lamp,
//           served_count out)
// ---------------------------------------------------------------------------
module crossing_request #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLDOFF_CYCLES  = 8
) (
  input  logic               clock,
  input  logic               reset,
  crossing_request_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF_CYCLES);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       s1, s2;
  logic       db, db_d;
  logic [7:0] dcnt;
  logic       press;

  state_t     state, state_nxt;
  logic [7:0] hcnt, hcnt_nxt;
  logic       again, again_nxt;
  logic [7:0] served, served_nxt;

  // Synchroniser and debouncer: db only follows s2 after it has differed
  // for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_d <= 1'b0;
      dcnt <= 8'd0;
    end else begin
      s1   <= bus.button;
      s2   <= s1;
      db_d <= db;
      if (s2 == db) begin
        dcnt <= 8'd0;
      end else if (dcnt == DB_LAST) begin
        db   <= ~db;
        dcnt <= 8'd0;
      end else begin
        dcnt <= dcnt + 8'd1;
      end
    end
  end

  // Rising edge of the debounced level only; releases are not requests.
  assign press = db & ~db_d;

  // Request FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      hcnt   <= 8'd0;
      again  <= 1'b0;
      served <= 8'd0;
    end else begin
      state  <= state_nxt;
      hcnt   <= hcnt_nxt;
      again  <= again_nxt;
      served <= served_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    hcnt_nxt   = hcnt;
    again_nxt  = again;
    served_nxt = served;
    case (state)
      IDLE: begin
        // walk wins; a press in the same cycle is dropped
        if (bus.walk)   state_nxt = SERVING;
        else if (press) state_nxt = PENDING;
      end
      PENDING: begin
        if (bus.walk) state_nxt = SERVING;
      end
      SERVING: begin
        if (!bus.walk) begin
          state_nxt  = HOLDOFF;
          hcnt_nxt   = HOLD_LOAD;
          served_nxt = sat_inc(served);
        end
      end
      HOLDOFF: begin
        // A press landing on the exit cycle still counts as a request.
        if (hcnt == 8'd1) begin
          state_nxt = (again | press) ? PENDING : IDLE;
          again_nxt = 1'b0;
        end else begin
          hcnt_nxt  = hcnt - 8'd1;
          again_nxt = again | press;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state only; no input reaches them directly.
  assign bus.start        = (state == PENDING);
  assign bus.wait_lamp    = (state == PENDING) | ((state == HOLDOFF) & again);
  assign bus.served_count = served;

endmodule

// File: tb/tb_crossing_request.sv
module tb_crossing_request;

  localparam int D = 4;
  localparam int H = 8;

  logic clock;
  logic reset;

  crossing_request_if bus();

  crossing_request #(
    .DEBOUNCE_CYCLES(D),
    .HOLDOFF_CYCLES (H)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit m_s1, m_s2;        // button as seen after one and two samples
  bit m_db, m_dbp;       // accepted level and its previous value
  int m_run;             // consecutive samples disagreeing with m_db
  bit m_pending;         // request outstanding (start level)
  bit m_serving;         // inside a walk phase
  int m_hold;            // hold-off cycles remaining, 0 = not holding off
  bit m_again;           // request taken during hold-off
  int m_count;           // completed walk phases

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0; m_run = 0;
    m_pending = 0; m_serving = 0; m_hold = 0; m_again = 0; m_count = 0;
  endtask

  task automatic model_edge(input bit b, input bit w);
    bit press;
    press = m_db && !m_dbp;
    m_dbp = m_db;
    if (m_s2 == m_db) m_run = 0;
    else if (m_run + 1 >= D) begin m_db = !m_db; m_run = 0; end
    else m_run = m_run + 1;
    m_s2 = m_s1;
    m_s1 = b;
    if (m_serving) begin
      if (!w) begin
        m_serving = 0;
        m_hold = H;
        if (m_count < 255) m_count = m_count + 1;
      end
    end else if (m_hold > 0) begin
      if (m_hold == 1) begin
        m_pending = m_again || press;
        m_again = 0;
        m_hold = 0;
      end else begin
        m_hold = m_hold - 1;
        if (press) m_again = 1;
      end
    end else begin
      if (w) begin m_pending = 0; m_serving = 1; end
      else if (press) m_pending = 1;
    end
  endtask

  task automatic check_model();
    check("model_start", 32'(bus.start), 32'(m_pending));
    check("model_wait", 32'(bus.wait_lamp), 32'(m_pending || (m_hold > 0 && m_again)));
    check("model_count", 32'(bus.served_count), m_count);
  endtask

  // Drive inputs off-edge, take one clock edge, compare 1 time unit later.
  task automatic step(input bit b, input bit w);
    bus.button = b;
    bus.walk   = w;
    @(posedge clock);
    model_edge(b, w);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clock);
    bus.button = 1'b0;
    bus.walk   = 1'b0;
    reset = 1'b1;
    model_reset();
    #2;
    check("rst_start", 32'(bus.start), 0);
    check("rst_wait", 32'(bus.wait_lamp), 0);
    check("rst_count", 32'(bus.served_count), 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- scripted vector table ----------------
  typedef struct {
    bit b;
    bit w;
    bit st;
    bit wt;
    int cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input bit b, input bit w,
                     input bit st, input bit wt, input int cnt);
    vec_t v;
    v.b = b; v.w = w; v.st = st; v.wt = wt; v.cnt = cnt;
    repeat (n) tbl.push_back(v);
  endtask

  initial begin
    reset      = 1'b1;
    bus.button = 1'b0;
    bus.walk   = 1'b0;
    model_reset();

    // Rows follow edge numbers after reset release, default parameters.
    add(6, 1, 0, 0, 0, 0);   // edges 1-6: press still being debounced
    add(4, 1, 0, 1, 1, 0);   // edges 7-10: request raised at edge 7
    add(2, 0, 0, 1, 1, 0);   // release does not drop the request
    add(3, 0, 1, 0, 0, 0);   // walk: start falls on first walk edge
    add(1, 0, 0, 0, 0, 1);   // edge 16: walk ends, count 1, hold-off
    add(8, 0, 0, 0, 0, 1);   // hold-off, back to idle at edge 24
    add(6, 1, 0, 0, 0, 1);   // edges 25-30: second press
    add(1, 0, 0, 1, 1, 1);   // edge 31: request
    add(4, 0, 0, 1, 1, 1);   // edges 32-35
    add(1, 1, 0, 1, 1, 1);   // edge 36: button pressed again early
    add(2, 1, 1, 0, 0, 1);   // edges 37-38: walk
    add(1, 1, 0, 0, 0, 2);   // edge 39: hold-off starts, count 2
    add(2, 1, 0, 0, 0, 2);   // edges 40-41: press accepted at edge 41
    add(4, 1, 0, 0, 1, 2);   // edges 42-45: again latched, lamp on
    add(1, 0, 0, 0, 1, 2);   // edge 46: last hold-off cycle
    add(2, 0, 0, 1, 1, 2);   // edge 47: start rises on exit edge
    add(1, 0, 1, 0, 0, 2);   // edge 49: walk
    add(1, 0, 0, 0, 0, 3);   // edge 50: count 3

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].b, tbl[i].w);
      check($sformatf("tbl%0d_start", i + 1), 32'(bus.start), 32'(tbl[i].st));
      check($sformatf("tbl%0d_wait", i + 1), 32'(bus.wait_lamp), 32'(tbl[i].wt));
      check($sformatf("tbl%0d_count", i + 1), 32'(bus.served_count), tbl[i].cnt);
    end

    // Bounce: single-cycle toggles, then a run one cycle too short.
    do_reset();
    begin
      bit pat[$];
      pat = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
              1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      foreach (pat[i]) begin
        step(pat[i], 1'b0);
        check("bounce_db", 32'(dut.db), 0);
        check("bounce_start", 32'(bus.start), 0);
      end
    end

    // Asynchronous reset while PENDING with the button held.
    do_reset();
    repeat (7) step(1'b1, 1'b0);
    check("pre_async_start", 32'(bus.start), 1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_start", 32'(bus.start), 0);
    check("async_wait", 32'(bus.wait_lamp), 0);
    reset = 1'b0;
    for (int k = 1; k <= 3 + D; k++) begin
      step(1'b1, 1'b0);
      check($sformatf("rearm_edge%0d", k), 32'(bus.start), (k == 3 + D) ? 1 : 0);
    end

    // Saturation over 257 walk phases.
    do_reset();
    for (int p = 1; p <= 257; p++) begin
      step(1'b0, 1'b1);
      repeat (H + 1) step(1'b0, 1'b0);
      if (p >= 254) check($sformatf("sat_phase%0d", p), 32'(bus.served_count), (p > 255) ? 255 : p);
    end

    // Randomised run against the model.
    do_reset();
    begin
      bit b, w;
      b = 0; w = 0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 6) == 0) b = !b;
        if ($urandom_range(0, 14) == 0) w = !w;
        step(b, w);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
